// File: rtl/llr_frame_loader_pkg.sv
// Shared frame geometry and fixed-point LLR format for the LLR frame loader.
package llr_frame_loader_pkg;
  localparam int LLR_N     = 12;
  localparam int LLR_LOG2N = 4;
  localparam int LLR_INT   = 8;
  localparam int LLR_FRAC  = 8;
  localparam int LLR_W     = LLR_INT + LLR_FRAC;

  typedef logic [LLR_W-1:0] llr_t;
endpackage

// File: rtl/llr_frame_bank.sv
// One frame bank: n hard bits plus n LLRs, write port, registered read port and full flag.
module llr_frame_bank #(
  parameter int n     = 12,
  parameter int log2n = 4,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [log2n-1:0] wr_addr_i,
  input  logic             wr_bit_i,
  input  logic [W-1:0]     wr_llr_i,
  input  logic             wr_last_i,
  input  logic             clr_i,
  input  logic             rd_sel_i,
  input  logic [log2n-1:0] rd_addr_i,
  output logic [W-1:0]     rd_llr_o,
  output logic             rd_bit_o,
  output logic [n-1:0]     bits_o,
  output logic             full_o
);
  localparam logic [log2n:0] N_EXT = (log2n+1)'(n);

  logic [W-1:0] llr_q [n];
  logic [n-1:0] bits_q;
  logic         full_q, full_d;
  logic [W-1:0] rd_llr_q, rd_llr_d;
  logic         rd_bit_q, rd_bit_d;
  logic         rd_hit;

  // A bank only answers reads while it is the presented bank and holds a complete frame.
  assign rd_hit = rd_sel_i && full_q && ({1'b0, rd_addr_i} < N_EXT);

  always_comb begin
    full_d   = full_q;
    rd_llr_d = '0;
    rd_bit_d = 1'b0;
    if (wr_en_i && wr_last_i) full_d = 1'b1;
    else if (clr_i)           full_d = 1'b0;
    if (rd_hit) begin
      rd_llr_d = llr_q[rd_addr_i];
      rd_bit_d = bits_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      llr_q[wr_addr_i]  <= wr_llr_i;
      bits_q[wr_addr_i] <= wr_bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= 1'b0;
      rd_llr_q <= '0;
      rd_bit_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      rd_llr_q <= rd_llr_d;
      rd_bit_q <= rd_bit_d;
    end
  end

  assign rd_llr_o = rd_llr_q;
  assign rd_bit_o = rd_bit_q;
  assign bits_o   = bits_q;
  assign full_o   = full_q;
endmodule

// File: rtl/llr_frame_loader.sv
// Ping-pong serial-to-frame loader feeding channel LLRs to a decoder.
// LLR_SIGNED_EN selects signed (+/-mag) LLRs; default stores mag for 1-bits, 0 otherwise.
module llr_frame_loader
  import llr_frame_loader_pkg::*;
#(
  parameter int n     = LLR_N,
  parameter int log2n = LLR_LOG2N,
  parameter int INT   = LLR_INT,
  parameter int FRAC  = LLR_FRAC,
  localparam int W    = INT + FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [W-1:0]     llr_mag,
  output logic             frame_valid,
  input  logic             frame_ack,
  input  logic [log2n-1:0] rd_addr,
  output logic [W-1:0]     rd_llr,
  output logic             rd_bit,
  output logic [n-1:0]     frame_bits,
  output logic [15:0]      frame_cnt
);
  localparam logic [log2n-1:0] LAST = log2n'(n - 1);

  logic [log2n-1:0] wr_ptr_q, wr_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic [1:0]   full;
  logic [W-1:0] bank_llr  [2];
  logic [1:0]   bank_bit;
  logic [n-1:0] bank_bits [2];
  logic         xfer, last, ack;
  logic [W-1:0] llr_w;

  assign in_ready    = ~full[wr_bank_q];
  assign frame_valid = full[rd_bank_q];
  assign xfer        = in_valid && in_ready;
  assign last        = (wr_ptr_q == LAST);
  assign ack         = frame_ack && frame_valid;

`ifdef LLR_SIGNED_EN
  assign llr_w = in_bit ? (~llr_mag + 1'b1) : llr_mag;
`else
  assign llr_w = in_bit ? llr_mag : '0;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    llr_frame_bank #(.n(n), .log2n(log2n), .W(W)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (xfer && (wr_bank_q == 1'(b))),
      .wr_addr_i (wr_ptr_q),
      .wr_bit_i  (in_bit),
      .wr_llr_i  (llr_w),
      .wr_last_i (last),
      .clr_i     (ack && (rd_bank_q == 1'(b))),
      .rd_sel_i  (rd_bank_q == 1'(b)),
      .rd_addr_i (rd_addr),
      .rd_llr_o  (bank_llr[b]),
      .rd_bit_o  (bank_bit[b]),
      .bits_o    (bank_bits[b]),
      .full_o    (full[b])
    );
  end

  // Only the presented bank can drive non-zero read data, so an OR merges them.
  assign rd_llr     = bank_llr[0] | bank_llr[1];
  assign rd_bit     = |bank_bit;
  assign frame_bits = frame_valid ? bank_bits[rd_bank_q] : '0;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    if (xfer) begin
      if (last) begin
        wr_ptr_d    = '0;
        wr_bank_d   = ~wr_bank_q;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    if (ack) rd_bank_d = ~rd_bank_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed scoreboard bench for llr_frame_loader (n=12, W=16); honours LLR_SIGNED_EN.
module tb_llr_frame_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_bit = 1'b0;
  logic [15:0] llr_mag = '0;
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_llr;
  logic        rd_bit;
  logic [11:0] frame_bits;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [11:0] frame_q [$];
  logic [16:0] rd_q [$];
  logic        cur_bits [12];
  logic [15:0] cur_mag  [12];
  logic [11:0] frm_a, frm_b, frm_c, frm_d, frm_e, frm_p;

  always #5 clk = ~clk;

  llr_frame_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .llr_mag(llr_mag), .frame_valid(frame_valid), .frame_ack(frame_ack), .rd_addr(rd_addr),
    .rd_llr(rd_llr), .rd_bit(rd_bit), .frame_bits(frame_bits), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] exp_llr(input logic b, input logic [15:0] m);
`ifdef LLR_SIGNED_EN
    return b ? (16'h0000 - m) : m;
`else
    return b ? m : 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends bits[start .. start+cnt-1]; optional frame_ack on the last transfer.
  task automatic send_bits(input logic [11:0] bits, input logic [15:0] mag0, input logic [15:0] step,
                           input int start, input int cnt, input bit ack_last);
    for (int i = start; i < start + cnt; i++) begin
      int guard = 0;
      in_valid  = 1'b1;
      in_bit    = bits[i];
      llr_mag   = mag0 + 16'(i) * step;
      frame_ack = ack_last && (i == start + cnt - 1);
      cur_bits[i] = bits[i];
      cur_mag[i]  = llr_mag;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      chk("in_ready_before_xfer", in_ready, 1);
      tick();
    end
    in_valid  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_queue"}, frame_q.size() != 0, 1);
    if (frame_q.size() != 0) chk(tag, frame_bits, frame_q.pop_front());
  endtask

  task automatic read_addr(input logic [3:0] a, input logic eb, input logic [15:0] el, input string tag);
    rd_addr = a;
    rd_q.push_back({eb, el});
    tick();
    chk({tag, "_queue"}, rd_q.size() != 0, 1);
    if (rd_q.size() != 0) chk(tag, {rd_bit, rd_llr}, rd_q.pop_front());
  endtask

  initial begin
    frm_a = 12'b101010101001;
    frm_b = 12'h5C3;
    frm_c = 12'h3A6;
    frm_d = 12'h0FF;
    frm_e = 12'hC35;
    frm_p = 12'h07F;

    #3 rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_rd_llr", rd_llr, 0);
    chk("rst_rd_bit", rd_bit, 0);
    chk("rst_frame_bits", frame_bits, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Frame A: fixed magnitude
    frame_q.push_back(frm_a);
    send_bits(frm_a, 16'hAACB, 16'h0000, 0, 11, 1'b0);
    chk("a_valid_before_last", frame_valid, 0);
    send_bits(frm_a, 16'hAACB, 16'h0000, 11, 1, 1'b0);
    chk("a_frame_valid", frame_valid, 1);
    chk("a_frame_bits_const", frame_bits, 12'b101010101001);
    check_frame("a_frame_bits");
    chk("a_frame_cnt", frame_cnt, 1);
`ifdef LLR_SIGNED_EN
    read_addr(4'd0, 1'b1, 16'h5535, "a_rd0");
    read_addr(4'd1, 1'b0, 16'hAACB, "a_rd1");
`else
    read_addr(4'd0, 1'b1, 16'hAACB, "a_rd0");
    read_addr(4'd1, 1'b0, 16'h0000, "a_rd1");
`endif
    read_addr(4'd11, 1'b1, exp_llr(1'b1, 16'hAACB), "a_rd11");
    read_addr(4'd13, 1'b0, 16'h0000, "a_rd13");
    chk("a_valid_after_rd13", frame_valid, 1);
    chk("a_cnt_after_rd13", frame_cnt, 1);

    // Frame B fills bank 1; both banks full, input stalls
    frame_q.push_back(frm_b);
    send_bits(frm_b, 16'h1234, 16'h0F1F, 0, 12, 1'b0);
    chk("b_frame_cnt", frame_cnt, 2);
    chk("b_in_ready_full", in_ready, 0);
    chk("b_still_shows_a", frame_bits, frm_a);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("stall_frame_cnt", frame_cnt, 2);
    chk("stall_in_ready", in_ready, 0);
    pulse_ack();
    chk("ack_in_ready", in_ready, 1);
    chk("ack_frame_valid", frame_valid, 1);
    check_frame("b_frame_bits");
    for (int i = 0; i < 12; i++)
      read_addr(4'(i), cur_bits[i], exp_llr(cur_bits[i], cur_mag[i]), "b_rd");
    read_addr(4'd15, 1'b0, 16'h0000, "b_rd15");

    // Frame C completes on the same edge B is acknowledged
    frame_q.push_back(frm_c);
    send_bits(frm_c, 16'h8001, 16'h0101, 0, 11, 1'b0);
    send_bits(frm_c, 16'h8001, 16'h0101, 11, 1, 1'b1);
    chk("c_frame_valid", frame_valid, 1);
    check_frame("c_frame_bits");
    chk("c_frame_cnt", frame_cnt, 3);
    chk("c_in_ready", in_ready, 1);
    read_addr(4'd2, frm_c[2], exp_llr(frm_c[2], 16'h8001 + 16'h0202), "c_rd2");

    // Release C, then an ack with nothing presented must be ignored
    pulse_ack();
    chk("c_acked_valid", frame_valid, 0);
    chk("c_acked_bits", frame_bits, 0);
    pulse_ack();
    chk("ign_ack_valid", frame_valid, 0);
    chk("ign_ack_ready", in_ready, 1);
    chk("ign_ack_cnt", frame_cnt, 3);
    read_addr(4'd0, 1'b0, 16'h0000, "inv_rd0");
    frame_q.push_back(frm_d);
    send_bits(frm_d, 16'h00F0, 16'h0003, 0, 12, 1'b0);
    chk("d_frame_valid", frame_valid, 1);
    check_frame("d_frame_bits");
    chk("d_frame_cnt", frame_cnt, 4);

    // Reset mid-frame discards everything
    send_bits(frm_p, 16'h7777, 16'h0001, 0, 7, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", frame_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_bits", frame_bits, 0);
    tick();
    rst = 1'b1;
    tick();
    frame_q.push_back(frm_e);
    send_bits(frm_e, 16'h0400, 16'h0011, 0, 11, 1'b0);
    chk("e_valid_before_last", frame_valid, 0);
    send_bits(frm_e, 16'h0400, 16'h0011, 11, 1, 1'b0);
    chk("e_frame_valid", frame_valid, 1);
    check_frame("e_frame_bits");
    chk("e_frame_cnt", frame_cnt, 1);
    read_addr(4'd5, frm_e[5], exp_llr(frm_e[5], 16'h0400 + 16'h0055), "e_rd5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
